// File: rtl/note_sequencer_ctrl.sv
// Song sequencer: fetches note words from a synchronous ROM, sounds each for its
// length in beat ticks, then inserts a rest gap. Define NOTE_SEQ_LOOP_EN to loop until stop.
module note_sequencer_ctrl #(
    parameter int TICK_DIV  = 12500000,
    parameter int SONG_LEN  = 42,
    parameter int ADDR_W    = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        note_code,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    localparam int CYC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_MAX = (GAP_TICKS > 15) ? GAP_TICKS : 15;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [3:0]        SILENCE   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          note_q, note_d;
    logic                valid_q, valid_d;
    logic [3:0]          len_q, len_d;     // last tick index of the current note
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                cyc_end;
    logic                adv;
    logic                hold;

    always_comb begin
        // NOTE: every next value takes its current value first, so no path leaves a latch behind.
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        valid_d = valid_q;
        len_d   = len_q;
        cyc_d   = cyc_q;
        tick_d  = tick_q;
        adv     = 1'b0;
        cyc_end = (cyc_q == CYC_LAST);

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            addr_d  = '0;
            note_d  = SILENCE;
            valid_d = 1'b0;
            len_d   = '0;
            cyc_d   = '0;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_FETCH;
                        addr_d  = '0;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    len_d = (rom_data[7:4] == 4'd0) ? 4'd0 : rom_data[7:4] - 4'd1;
                    if (rom_data[3:0] == 4'd0) begin
                        note_d  = SILENCE;
                        valid_d = 1'b0;
                    end else begin
                        note_d  = rom_data[3:0];
                        valid_d = 1'b1;
                    end
                    cyc_d   = '0;
                    tick_d  = '0;
                    state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (!pause) begin
                        if (!cyc_end) begin
                            cyc_d = cyc_q + CYC_W'(1);
                        end else if (tick_q != TICK_W'(len_q)) begin
                            cyc_d  = '0;
                            tick_d = tick_q + TICK_W'(1);
                        end else if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                            note_d  = SILENCE;
                            valid_d = 1'b0;
                            cyc_d   = '0;
                            tick_d  = '0;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!pause) begin
                        if (!cyc_end) begin
                            cyc_d = cyc_q + CYC_W'(1);
                        end else if (tick_q != GAP_LAST) begin
                            cyc_d  = '0;
                            tick_d = tick_q + TICK_W'(1);
                        end else begin
                            adv = 1'b1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            // The previous note stays on the mux until the next word is latched.
            if (adv) begin
                cyc_d  = '0;
                tick_d = '0;
                if (addr_q == ADDR_LAST) begin
`ifdef NOTE_SEQ_LOOP_EN
                    addr_d  = '0;
                    state_d = S_FETCH;
`else
                    addr_d  = '0;
                    state_d = S_DONE;
                    note_d  = SILENCE;
                    valid_d = 1'b0;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            note_q  <= SILENCE;
            valid_q <= 1'b0;
            len_q   <= '0;
            cyc_q   <= '0;
            tick_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
        end
    end

    // Pause masks the output in the same cycle the counters freeze, so no time is lost.
    assign hold       = pause && (state_q == S_PLAY || state_q == S_GAP);
    assign note_code  = hold ? SILENCE : note_q;
    assign note_valid = valid_q && !hold;
    assign rom_addr   = addr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: doc/note_sequencer_ctrl.md
Name: note_sequencer_ctrl

Overview:
Sequencer that steps a tone-generator datapath through a song held in an external synchronous note ROM. It fetches one note word per step, holds the note code for its programmed length in beat ticks, then inserts an inter-note rest gap. It supports start, stop and pause, and reports busy and done. It sits between the song ROM and the note-select mux that gates the per-pitch divider clocks onto the speaker output.

Parameters:
TICK_DIV, 12500000, clk cycles per beat tick (sim value 4)
SONG_LEN, 42, number of note words in ROM, addresses 0..SONG_LEN-1
ADDR_W, 6, ROM address width; must satisfy SONG_LEN <= 2**ADDR_W
GAP_TICKS, 1, rest ticks inserted after every note; 0 = no gap

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  level; sampled in IDLE only
stop  input  1  level; abort playback
pause  input  1  level; freeze playback while high
rom_addr  output  ADDR_W  note ROM address, registered
rom_data  input  8  ROM word: [3:0] note code (1..8 pitch, 0 = rest), [7:4] length in ticks; valid one cycle after rom_addr
note_code  output  4  pitch select to the mux; 4'd15 = silence
note_valid  output  1  high while a pitched note is sounding
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at song end

Behaviour:
- Reset (async, any time): state IDLE, rom_addr 0, note_code 15, note_valid 0, busy 0, done 0, tick and cycle counters 0.
- States: IDLE, FETCH, LATCH, PLAY, GAP, DONE.
- IDLE: start=1 and stop=0 -> FETCH, rom_addr=0, busy=1.
- FETCH: one cycle with rom_addr stable -> LATCH.
- LATCH: capture rom_data; len = rom_data[7:4], and len 0 is treated as 1. Note code 0 loads as 15 with note_valid=0; otherwise note_code=rom_data[3:0] and note_valid=1. -> PLAY.
- Latency: start sampled at edge N -> FETCH at N+1, LATCH at N+2, note_code/note_valid updated at edge N+3.
- PLAY: cycle counter runs 0..TICK_DIV-1, and tick counter increments on wrap. After len*TICK_DIV cycles: if GAP_TICKS>0 -> GAP, else -> advance.
- GAP: note_code=15, note_valid=0 for GAP_TICKS*TICK_DIV cycles -> advance.
- Advance: if rom_addr==SONG_LEN-1 -> DONE. Otherwise rom_addr+1 -> FETCH, with note_code and note_valid held until the next LATCH.
- DONE: done=1 for one cycle, note_code=15, note_valid=0, rom_addr=0 -> IDLE (busy=0 from the following cycle).
- Counters are zeroed on every entry to PLAY and GAP.
- pause=1 in PLAY/GAP: counters freeze, note_code forced 15, note_valid 0. On release the saved note is restored, and the remaining time continues with no cycle lost or added. Pause has no effect in FETCH/LATCH, which complete, so pause takes effect in the next PLAY.
- stop=1 in any non-IDLE state: next cycle IDLE with reset values. done is not pulsed. stop has priority over start, pause and the end-of-note transition.
- start while busy is ignored. start held high in IDLE after DONE restarts the song (level-sensitive).
- rom_addr never exceeds SONG_LEN-1.

Optional Feature:
NOTE_SEQ_LOOP_EN
- Defined: at the advance from the last address, no DONE and no done pulse. Go rom_addr=0 -> FETCH and loop until stop; busy stays 1.
- Undefined: behaviour as above (single pass, DONE, done pulse).

Test Plan:
1. TICK_DIV=4, GAP_TICKS=1, SONG_LEN=3, ROM {0x11,0x25,0x06}; start pulse at cycle 0 -> note_code 1 from cycle 3 for 4 cycles, 15 for 4 cycles. Then note 5 for 8 cycles, then note 6 for 4 cycles (len 0 -> 1). Then gap, done pulse exactly once, busy low.
2. ROM word 0x20 (rest, len 2) -> note_code 15, note_valid 0 for 8 cycles, then gap; rom_addr advances normally.
3. pause high for 10 cycles starting 2 cycles into a 4-cycle note -> output 15 during the pause. The note resumes and sounds for the 2 remaining cycles; total sequence is 10 cycles longer.
4. stop asserted mid-PLAY at address 1 together with start -> next cycle IDLE, rom_addr 0, note_code 15, busy 0, no done. A later start replays from address 0.
5. rst asserted asynchronously mid-GAP (between clock edges) -> outputs at reset values immediately, with no clock edge required.
6. With NOTE_SEQ_LOOP_EN defined, SONG_LEN=3 -> after address 2 the sequence goes FETCH at address 0, done never pulses, busy stays 1 across 2 full passes.
